vga_scan_engine: RTL

- Scan-side master for the menu/game pixel processors.
- Walks the 640x480@60 raster and emits the linear pixel address `curAddress` for a processor to remap.
- Registers the remapped `addrToRead` into the image index ROM, routes the returned index to the palette, and outputs RGB.
- hsync, vsync and blank are delayed to line up with RGB; a once-per-frame tick lets upstream latch score and time values during vblank.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_scan_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing, width constants and sideband type for the VGA scan engine
package vga_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BACK     = 48;
    localparam int V_VISIBLE  = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PIPE_DEPTH = 4;

    localparam int ADDR_W   = 19;
    localparam int INDEX_W  = 8;
    localparam int COLOR_W  = 24;
    localparam int SCREEN_W = 640;
    localparam int CNT_W    = 10;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } sideband_t;

    localparam sideband_t SB_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with a synchronous reset value
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - raster counters, ROM/palette fetch pipeline and aligned sync outputs
module vga_scan_engine #(
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter int PIPE_DEPTH = vga_pkg::PIPE_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         pix_en,
    output logic [vga_pkg::ADDR_W-1:0]   curAddress,
    input  logic [vga_pkg::ADDR_W-1:0]   addrToRead,
    output logic [vga_pkg::ADDR_W-1:0]   memAddr,
    input  logic [vga_pkg::INDEX_W-1:0]  memIndex,
    output logic [vga_pkg::INDEX_W-1:0]  palIndex,
    input  logic [vga_pkg::COLOR_W-1:0]  palColor,
    output logic [7:0]                   r,
    output logic [7:0]                   g,
    output logic [7:0]                   b,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         blank_n,
    output logic                         frame_tick
);
    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               blank_n_q, blank_n_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;

    logic      vis;
    sideband_t sb_raw;
    sideband_t sb_late;

    always_comb begin
        vis        = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
        sb_raw.vis = vis;
        sb_raw.hs  = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
        sb_raw.vs  = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
        curAddress = vis ? (ADDR_W'(vcnt_q) * ADDR_W'(H_VISIBLE) + ADDR_W'(hcnt_q)) : '0;
    end

    // The sideband lags by one fewer stage than the output so its tap lines up with palColor.
    vga_delay_line #(
        .WIDTH     ($bits(sideband_t)),
        .DEPTH     (PIPE_DEPTH - 1),
        .RESET_VAL (SB_IDLE)
    ) u_sideband_dly (
        .clock (clock),
        .reset (reset),
        .en    (pix_en),
        .din   (sb_raw),
        .dout  (sb_late)
    );

    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        mem_addr_d = mem_addr_q;
        rgb_d      = rgb_q;
        blank_n_d  = blank_n_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        if (pix_en) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            mem_addr_d = addrToRead;
            rgb_d      = sb_late.vis ? palColor : '0;
            blank_n_d  = sb_late.vis;
            hsync_d    = sb_late.hs;
            vsync_d    = sb_late.vs;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            mem_addr_q <= '0;
            rgb_q      <= '0;
            blank_n_q  <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            mem_addr_q <= mem_addr_d;
            rgb_q      <= rgb_d;
            blank_n_q  <= blank_n_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign memAddr    = mem_addr_q;
    assign palIndex   = memIndex;
    assign r          = rgb_q[23:16];
    assign g          = rgb_q[15:8];
    assign b          = rgb_q[7:0];
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign blank_n    = blank_n_q;
    assign frame_tick = pix_en && !reset && (hcnt_q == '0) && (vcnt_q == V_VIS_C);

endmodule
